// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the shared memory port arbiter.
// Flow control is grant/wready/rvalid driven; requesters cannot stall a granted burst.
interface mem_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 4
);
  logic [NUM_MASTERS-1:0]            req;
  logic [NUM_MASTERS-1:0]            write;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr;
  logic [NUM_MASTERS*LEN_WIDTH-1:0]  len;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] wdata;
  logic [NUM_MASTERS-1:0]            grant;
  logic [NUM_MASTERS-1:0]            wready;
  logic [NUM_MASTERS-1:0]            rvalid;
  logic [NUM_MASTERS-1:0]            done;
  logic [DATA_WIDTH-1:0]             rdata;
  logic                              busy;
  logic [ADDR_WIDTH-1:0]             mem_address;
  logic                              mem_enable;
  logic                              mem_mode;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic [DATA_WIDTH-1:0]             mem_rdata;

  modport master (
    output req, write, addr, len, wdata, mem_rdata,
    input  grant, wready, rvalid, done, rdata, busy,
    input  mem_address, mem_enable, mem_mode, mem_wdata
  );

  modport slave (
    input  req, write, addr, len, wdata, mem_rdata,
    output grant, wready, rvalid, done, rdata, busy,
    output mem_address, mem_enable, mem_mode, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting whole incrementing bursts on one 8-bit sync memory port.
// Latency: 1 arbitration cycle, N beat cycles, 1 finish cycle; read data 1 cycle after strobe; no backpressure.
module mem_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int LEN_WIDTH   = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  mem_arbiter_if.slave  bus_io
);
  localparam int OW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, XFER, FINISH} state_e;

  state_e                 state_q;
  logic [OW-1:0]          owner_q;
  logic [OW-1:0]          rr_ptr_q;
  logic [ADDR_WIDTH-1:0]  addr_cnt_q;
  logic [LEN_WIDTH-1:0]   beats_left_q;
  logic                   dir_q;
  logic                   rd_pending_q;

  logic                   win_vld;
  logic [OW-1:0]          win_idx;

  logic [NUM_MASTERS-1:0] grant_c;
  logic [NUM_MASTERS-1:0] wready_c;
  logic [NUM_MASTERS-1:0] rvalid_c;
  logic [NUM_MASTERS-1:0] done_c;
  logic [ADDR_WIDTH-1:0]  mem_address_c;
  logic                   mem_enable_c;
  logic                   mem_mode_c;
  logic [DATA_WIDTH-1:0]  mem_wdata_c;

  function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return OW'(s);
  endfunction

  // First requester at or after rr_ptr, wrapping past the top index.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr_q;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!win_vld && bus_io.req[rr_idx(rr_ptr_q, i)]) begin
        win_vld = 1'b1;
        win_idx = rr_idx(rr_ptr_q, i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      addr_cnt_q   <= '0;
      beats_left_q <= '0;
      dir_q        <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_pending_q <= 1'b0;
          if (win_vld) begin
            owner_q      <= win_idx;
            addr_cnt_q   <= bus_io.addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            beats_left_q <= bus_io.len[win_idx*LEN_WIDTH +: LEN_WIDTH];
            dir_q        <= bus_io.write[win_idx];
            state_q      <= XFER;
          end
        end
        XFER: begin
          addr_cnt_q   <= addr_cnt_q + ADDR_WIDTH'(1);
          beats_left_q <= beats_left_q - LEN_WIDTH'(1);
          rd_pending_q <= ~dir_q;
          if (beats_left_q == '0) state_q <= FINISH;
        end
        FINISH: begin
          rd_pending_q <= 1'b0;
          rr_ptr_q     <= (owner_q == OW'(NUM_MASTERS - 1)) ? '0 : owner_q + OW'(1);
          state_q      <= IDLE;
        end
        default: begin
          rd_pending_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registers directly so an async reset clears them at once.
  always_comb begin
    grant_c       = '0;
    wready_c      = '0;
    rvalid_c      = '0;
    done_c        = '0;
    mem_address_c = '0;
    mem_enable_c  = 1'b0;
    mem_mode_c    = 1'b0;
    mem_wdata_c   = '0;
    case (state_q)
      XFER: begin
        grant_c[owner_q]  = 1'b1;
        wready_c[owner_q] = dir_q;
        mem_enable_c      = 1'b1;
        mem_address_c     = addr_cnt_q;
        mem_mode_c        = dir_q;
        mem_wdata_c       = bus_io.wdata[owner_q*DATA_WIDTH +: DATA_WIDTH];
      end
      FINISH: begin
        grant_c[owner_q] = 1'b1;
        done_c[owner_q]  = 1'b1;
      end
      default: ;
    endcase
    rvalid_c[owner_q] = rd_pending_q;
  end

  assign bus_io.grant       = grant_c;
  assign bus_io.wready      = wready_c;
  assign bus_io.rvalid      = rvalid_c;
  assign bus_io.done        = done_c;
  assign bus_io.rdata       = rd_pending_q ? bus_io.mem_rdata : '0;
  assign bus_io.busy        = (state_q != IDLE);
  assign bus_io.mem_address = mem_address_c;
  assign bus_io.mem_enable  = mem_enable_c;
  assign bus_io.mem_mode    = mem_mode_c;
  assign bus_io.mem_wdata   = mem_wdata_c;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level schedule model checked every cycle plus directed literal checks.
// Inputs change 2 time units after the rising edge; the model compares on the falling edge.
module tb_mem_arbiter;
  localparam int NM = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NM-1:0]    req;
  logic [NM-1:0]    wr;
  logic [NM*AW-1:0] addr;
  logic [NM*LW-1:0] len;
  logic [NM*DW-1:0] wdata;
  logic [DW-1:0]    mem_rdata_r;

  mem_arbiter_if #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus_if ();

  assign bus_if.req       = req;
  assign bus_if.write     = wr;
  assign bus_if.addr      = addr;
  assign bus_if.len       = len;
  assign bus_if.wdata     = wdata;
  assign bus_if.mem_rdata = mem_rdata_r;

  mem_arbiter #(.NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus_io  (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Synchronous memory seen by the arbiter, and the model's own copy of it.
  logic [7:0] mem  [0:65535];
  logic [7:0] mmem [0:65535];

  always @(posedge clk) begin
    if (bus_if.mem_enable) begin
      if (bus_if.mem_mode) mem[bus_if.mem_address] = bus_if.mem_wdata;
      else mem_rdata_r <= mem[bus_if.mem_address];
    end
  end

  // One record per expected busy cycle: each beat, then the finish cycle.
  typedef struct {
    int          owner;
    bit          fin;
    logic [15:0] a;
    bit          dir;
    bit          rv;
    logic [15:0] rva;
  } rec_t;

  rec_t        exp_q[$];
  int          m_rr = 0;
  int          m_win;
  logic [15:0] m_a0;
  int          m_n;
  bit          m_d;
  rec_t        m_r;
  logic [NM-1:0] m_oh;
  logic [7:0]  m_wd;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_grant", bus_if.grant, 0);
      chk("rst_wready", bus_if.wready, 0);
      chk("rst_rvalid", bus_if.rvalid, 0);
      chk("rst_done", bus_if.done, 0);
      chk("rst_busy", bus_if.busy, 0);
      chk("rst_mem_enable", bus_if.mem_enable, 0);
      chk("rst_mem_mode", bus_if.mem_mode, 0);
      chk("rst_mem_address", bus_if.mem_address, 0);
      chk("rst_mem_wdata", bus_if.mem_wdata, 0);
      chk("rst_rdata", bus_if.rdata, 0);
      exp_q.delete();
      m_rr = 0;
    end else if (exp_q.size() == 0) begin
      chk("idle_grant", bus_if.grant, 0);
      chk("idle_wready", bus_if.wready, 0);
      chk("idle_rvalid", bus_if.rvalid, 0);
      chk("idle_done", bus_if.done, 0);
      chk("idle_busy", bus_if.busy, 0);
      chk("idle_mem_enable", bus_if.mem_enable, 0);
      chk("idle_rdata", bus_if.rdata, 0);
      m_win = -1;
      for (int off = 0; off < NM; off++)
        if (m_win < 0 && req[(m_rr + off) % NM]) m_win = (m_rr + off) % NM;
      if (m_win >= 0) begin
        m_a0 = addr[m_win*AW +: AW];
        m_n  = int'(len[m_win*LW +: LW]);
        m_d  = wr[m_win];
        for (int b = 0; b <= m_n; b++) begin
          m_r.owner = m_win;
          m_r.fin   = 1'b0;
          m_r.a     = m_a0 + 16'(b);
          m_r.dir   = m_d;
          m_r.rv    = !m_d && (b > 0);
          m_r.rva   = m_a0 + 16'(b) - 16'd1;
          exp_q.push_back(m_r);
        end
        m_r.owner = m_win;
        m_r.fin   = 1'b1;
        m_r.a     = m_a0 + 16'(m_n);
        m_r.dir   = m_d;
        m_r.rv    = !m_d;
        m_r.rva   = m_a0 + 16'(m_n);
        exp_q.push_back(m_r);
        m_rr = (m_win + 1) % NM;
      end
    end else begin
      m_r  = exp_q.pop_front();
      m_oh = NM'(1) << m_r.owner;
      chk("grant", bus_if.grant, m_oh);
      chk("wready", bus_if.wready, (!m_r.fin && m_r.dir) ? m_oh : '0);
      chk("rvalid", bus_if.rvalid, m_r.rv ? m_oh : '0);
      chk("done", bus_if.done, m_r.fin ? m_oh : '0);
      chk("busy", bus_if.busy, 1);
      chk("mem_enable", bus_if.mem_enable, !m_r.fin);
      if (!m_r.fin) begin
        m_wd = wdata[m_r.owner*DW +: DW];
        chk("mem_mode", bus_if.mem_mode, m_r.dir);
        chk("mem_address", bus_if.mem_address, m_r.a);
        chk("mem_wdata", bus_if.mem_wdata, m_wd);
        if (m_r.dir) mmem[m_r.a] = m_wd;
      end
      chk("rdata", bus_if.rdata, m_r.rv ? mmem[m_r.rva] : 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_m(input int m, input bit w, input logic [15:0] a, input logic [3:0] l,
                       input logic [7:0] d);
    wr[m]            = w;
    addr[m*AW +: AW] = a;
    len[m*LW +: LW]  = l;
    wdata[m*DW +: DW] = d;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    mem[a]  = d;
    mmem[a] = d;
  endtask

  int            st_cyc[$];
  int            st_own[$];
  logic [NM-1:0] prev_g;
  int            exp_cyc[6] = '{1, 4, 7, 10, 13, 16};
  int            exp_own[6] = '{0, 1, 2, 0, 1, 2};
  int            wr_cnt;
  int            dn_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    req = '0; wr = '0; addr = '0; len = '0; wdata = '0; rst_n = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem[i]  = 8'(i) ^ 8'h5A;
      mmem[i] = 8'(i) ^ 8'h5A;
    end
    #3;
    chk("reset_grant", bus_if.grant, 0);
    chk("reset_busy", bus_if.busy, 0);
    chk("reset_mem_enable", bus_if.mem_enable, 0);
    chk("reset_rdata", bus_if.rdata, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Round robin: all three hold read requests with len 0.
    set_m(0, 1'b0, 16'h0010, 4'd0, 8'h00);
    set_m(1, 1'b0, 16'h0020, 4'd0, 8'h00);
    set_m(2, 1'b0, 16'h0030, 4'd0, 8'h00);
    req = 3'b111;
    prev_g = '0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      chk("rr_onehot", ($countones(bus_if.grant) <= 1), 1);
      if (bus_if.grant != 0 && prev_g == 0) begin
        st_cyc.push_back(c);
        st_own.push_back($clog2(bus_if.grant));
      end
      prev_g = bus_if.grant;
      if (c == 18) req = '0;
    end
    chk("rr_starts", st_cyc.size(), 6);
    for (int k = 0; k < 6 && k < st_cyc.size(); k++) begin
      chk("rr_start_cycle", st_cyc[k], exp_cyc[k]);
      chk("rr_owner", st_own[k], exp_own[k]);
    end
    tick();

    // Pointer priority: after M0 finishes, M0 and M2 request together.
    set_m(0, 1'b0, 16'h0040, 4'd0, 8'h00);
    set_m(2, 1'b0, 16'h0050, 4'd0, 8'h00);
    req = 3'b001;
    tick(); req = 3'b000;
    tick(); req = 3'b101;
    tick();
    tick(); chk("prio_first", bus_if.grant, 3'b100); req = 3'b001;
    tick();
    tick();
    tick(); chk("prio_second", bus_if.grant, 3'b001); req = 3'b000;
    tick();
    tick();

    // Single write from M1.
    set_m(1, 1'b1, 16'h1234, 4'd0, 8'hA5);
    req = 3'b010;
    tick();
    chk("sw_grant", bus_if.grant, 3'b010);
    chk("sw_mem_enable", bus_if.mem_enable, 1);
    chk("sw_mem_mode", bus_if.mem_mode, 1);
    chk("sw_mem_address", bus_if.mem_address, 16'h1234);
    chk("sw_mem_wdata", bus_if.mem_wdata, 8'hA5);
    chk("sw_wready", bus_if.wready, 3'b010);
    req = 3'b000;
    tick(); chk("sw_done", bus_if.done, 3'b010);
    tick(); chk("sw_busy", bus_if.busy, 0);
    chk("sw_mem", mem[16'h1234], 8'hA5);

    // Read burst wrapping the address space.
    preload(16'hFFFE, 8'h11);
    preload(16'hFFFF, 8'h22);
    preload(16'h0000, 8'h33);
    set_m(0, 1'b0, 16'hFFFE, 4'd2, 8'h00);
    req = 3'b001;
    tick(); chk("wrap_addr0", bus_if.mem_address, 16'hFFFE); req = 3'b000;
    tick(); chk("wrap_addr1", bus_if.mem_address, 16'hFFFF);
    chk("wrap_rvalid0", bus_if.rvalid, 3'b001); chk("wrap_rdata0", bus_if.rdata, 8'h11);
    tick(); chk("wrap_addr2", bus_if.mem_address, 16'h0000);
    chk("wrap_rvalid1", bus_if.rvalid, 3'b001); chk("wrap_rdata1", bus_if.rdata, 8'h22);
    tick(); chk("wrap_done", bus_if.done, 3'b001);
    chk("wrap_rvalid2", bus_if.rvalid, 3'b001); chk("wrap_rdata2", bus_if.rdata, 8'h33);
    tick(); chk("wrap_busy", bus_if.busy, 0);

    // Request withdrawal during a 4-beat write.
    set_m(1, 1'b1, 16'h0100, 4'd3, 8'hC0);
    req = 3'b010;
    wr_cnt = 0;
    dn_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) req = 3'b000;
      if (k <= 4) wdata[1*DW +: DW] = 8'hC0 + 8'(k - 1);
      if (bus_if.wready[1]) wr_cnt++;
      if (bus_if.done[1]) dn_cnt++;
    end
    chk("wd_wready_count", wr_cnt, 4);
    chk("wd_done_count", dn_cnt, 1);
    chk("wd_mem0", mem[16'h0100], 8'hC0);
    chk("wd_mem3", mem[16'h0103], 8'hC3);

    // Reset during the second beat of an M2 read burst.
    set_m(2, 1'b0, 16'h0200, 4'd3, 8'h00);
    req = 3'b100;
    tick(); req = 3'b000;
    tick(); chk("mr_pre_grant", bus_if.grant, 3'b100);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_grant", bus_if.grant, 0);
    chk("mr_mem_enable", bus_if.mem_enable, 0);
    chk("mr_rvalid", bus_if.rvalid, 0);
    tick(); chk("mr_done_a", bus_if.done, 0);
    tick(); chk("mr_done_b", bus_if.done, 0);
    rst_n = 1'b1;
    tick();
    set_m(1, 1'b0, 16'h0300, 4'd0, 8'h00);
    req = 3'b010;
    tick();
    chk("mr_new_grant", bus_if.grant, 3'b010);
    chk("mr_new_addr", bus_if.mem_address, 16'h0300);
    req = 3'b000;
    tick();
    chk("mr_new_done", bus_if.done, 3'b010);
    chk("mr_new_rdata", bus_if.rdata, 8'h5A);
    tick(); chk("mr_new_busy", bus_if.busy, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
